vector_streamer: RTL and testbench
==================================

Name: vector_streamer

Overview:
- Holds one frame of LEN 16-bit fixed-point samples and replays it as a one-sample-per-beat stream with a valid/ready handshake and an end-of-frame done pulse.
- It is the source side of the 133-beat accumulation path: it produces the stream that the downstream summing buffer consumes.
- A host writes the frame through a simple write port, then pulses start. One frame is emitted per start.

Parameters:
- DW, 16, sample width (Q-format is transparent; no arithmetic is performed on data).
- LEN, 133, samples per frame; legal range 2..256.
- AW, 8, address and counter width; must satisfy 2^AW >= LEN.

Ports:
- clk  input  1  sole clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  frame-memory write strobe.
- wr_addr  input  AW  write address, 0..LEN-1.
- wr_data  input  DW  write data.
- start  input  1  single-cycle request to stream the stored frame.
- out_ready  input  1  downstream accepts the current beat.
- out_valid  output  1  data_out holds a valid sample.
- data_out  output  DW  current sample.
- out_last  output  1  current beat is sample LEN-1.
- busy  output  1  a frame is in progress (state is not IDLE).
- done  output  1  one-cycle pulse after the last beat transfers.
- wr_err  output  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; rd_ptr=0 and beat_cnt=0.
  - out_valid, data_out, out_last, busy, done and wr_err all go to 0.
  - Frame memory is not cleared. Reset takes priority over every other input.
- Memory: LEN x DW, one write port, one read port, reads are registered. Contents survive reset and frames.
- Writes:
  - Accepted only in IDLE when wr_addr < LEN.
  - A write while busy=1, or with wr_addr >= LEN, is ignored; wr_err=1 on the next cycle.
  - A write and a start in the same IDLE cycle: the write commits first, and the stream sees the new value.
- A beat transfers on any edge where out_valid=1 and out_ready=1.
- State IDLE:
  - start=1 moves to STREAM with rd_ptr=0 and busy=1 the next cycle.
  - The first beat appears with out_valid=1 one cycle after that, so start-to-first-valid latency is 2 cycles.
- State STREAM:
  - The output register loads mem[rd_ptr] and rd_ptr increments whenever (out_valid=0 or out_ready=1) and rd_ptr < LEN.
  - When out_valid=1 and out_ready=0, data_out and out_last hold stable; no bubble is inserted and no beat is dropped or duplicated.
  - Once the pipeline is primed and out_ready is held high, throughput is 1 beat per cycle.
  - out_last=1 exactly with the beat carrying sample LEN-1.
  - beat_cnt counts transferred beats.
  - When the last beat transfers, the block moves to DONE and out_valid drops to 0 on the same edge unless a new beat loads (none remains).
- State DONE: lasts one cycle; done=1 and busy=1 during it; then returns to IDLE.
- start while busy is ignored, with no queuing and no error.
- Reset mid-frame: the frame is aborted immediately, no done pulse is produced, and a fresh start replays from sample 0.
- out_ready held low indefinitely: the block stalls with no timeout.
- Frame length: exactly LEN beats per start, independent of the out_ready pattern.

Decomposition:
- Shared package vae_pkg holds:
  - DATA_W=16 and FRAME_LEN=133.
  - State encoding localparams: IDLE=2'd0, STREAM=2'd1, DONE=2'd2.
- One sub-module, frame_ram: LEN x DW with a synchronous write port and a registered read port. It holds no control logic, so it can later be swapped for an inferred BRAM.
- FSM, pointers and output register stay in vector_streamer.

Test Plan:
- Streaming with out_ready held high:
  - Stimulus: write mem[i]=16'h0100+i for i=0..132, then pulse start.
  - Response: first out_valid 2 cycles after start; beats 0x0100..0x0184 on consecutive cycles; out_last only on 0x0184; done pulses exactly once, 1 cycle after the last transfer; busy high from start+1 through the DONE cycle.
- Backpressure:
  - Stimulus: same frame, out_ready toggling 1,0,0,1,...
  - Response: 133 beats in order with no duplicates; data_out stable during every stall cycle.
- Rejected writes:
  - Stimulus: wr_en with wr_addr=133; separately, wr_en during STREAM.
  - Response: wr_err pulses once per rejected write; the streamed data is unchanged.
- Start while busy:
  - Stimulus: start pulsed at beat 50.
  - Response: ignored; exactly 133 beats and 1 done are produced.
- Reset mid-frame:
  - Stimulus: rst=1 for 1 cycle at beat 70, then start.
  - Response: all outputs are 0 the cycle after reset; no done for the aborted frame; the new frame starts at sample 0 with the memory contents intact.
- Same-cycle write and start:
  - Stimulus: in IDLE, wr_en with wr_addr=0, wr_data=16'hBEEF together with start.
  - Response: the first beat carries 16'hBEEF.

Source files
------------

// File: rtl/vae_pkg.sv
// Shared definitions for the accumulation path: sample/frame sizing and the
// streamer state encoding.
package vae_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAME_LEN = 133;
  localparam int unsigned ADDR_W    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/vector_streamer_if.sv
// Valid/ready sample stream between the frame source and its consumer.
interface vector_streamer_if #(
  parameter int unsigned DW = vae_pkg::DATA_W
);

  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [DW-1:0] data_out;

  modport master (output out_valid, output data_out, output out_last, input out_ready);
  modport slave  (input out_valid, input data_out, input out_last, output out_ready);

endinterface

// File: rtl/vector_streamer_frame_ram.sv
// Frame storage: synchronous write port, registered read port with enable.
// The read register is cleared by reset so the stream data reads 0 after reset.
module frame_ram #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 133,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are deliberately not reset; they persist across resets and frames.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/vector_streamer.sv
// Replays a stored frame of LEN samples as a valid/ready stream, one frame per
// start pulse, with a done pulse after the last beat is accepted.
module vector_streamer
  import vae_pkg::*;
#(
  parameter int unsigned DW  = DATA_W,
  parameter int unsigned LEN = FRAME_LEN,
  parameter int unsigned AW  = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  input  logic                start,
  vector_streamer_if.master   strm,
  output logic                busy,
  output logic                done,
  output logic                wr_err
);

  // One extra bit so the pointer can reach LEN even when LEN == 2**AW.
  localparam int unsigned PW = AW + 1;

  state_t        state;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] beat_cnt;
  logic          valid_q;
  logic          last_q;
  logic [DW-1:0] rdata;

  logic          wr_ok;
  logic          load;
  logic          xfer;

  assign wr_ok = wr_en && (state == IDLE) && ({1'b0, wr_addr} < PW'(LEN));
  assign xfer  = valid_q && strm.out_ready;
  assign load  = (state == STREAM) && (!valid_q || strm.out_ready) && (rd_ptr < PW'(LEN));

  frame_ram #(
    .DW    (DW),
    .DEPTH (LEN),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (load),
    .raddr (AW'(rd_ptr)),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      beat_cnt <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= STREAM;
            rd_ptr   <= '0;
            beat_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        STREAM: begin
          // Output register refills whenever it is empty or being drained.
          if (load) begin
            rd_ptr  <= rd_ptr + PW'(1);
            valid_q <= 1'b1;
            last_q  <= (rd_ptr == PW'(LEN - 1));
          end else if (xfer) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
          if (xfer) begin
            beat_cnt <= beat_cnt + PW'(1);
          end
          if (xfer && last_q) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign strm.out_valid = valid_q;
  assign strm.out_last  = last_q;
  assign strm.data_out  = rdata;

endmodule

// File: tb/tb_vector_streamer.sv
// Scoreboard bench for vector_streamer: stimulus pushes expected beats, a
// negedge monitor pops and compares every accepted beat.
module tb_vector_streamer;
  import vae_pkg::*;

  localparam int unsigned DW  = DATA_W;
  localparam int unsigned LEN = FRAME_LEN;
  localparam int unsigned AW  = ADDR_W;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            idx;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          busy, done, wr_err;

  vector_streamer_if #(.DW(DW)) strm ();

  vector_streamer #(.DW(DW), .LEN(LEN), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .strm    (strm),
    .busy    (busy),
    .done    (done),
    .wr_err  (wr_err)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_done   = 0;
  int            cyc      = 0;
  int            first_cyc = 0;
  int            last_cyc  = 0;
  logic [DW-1:0] exp_mem [LEN];
  beat_t         exp_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every accepted beat, checks stalls and done timing.
  logic          stall_pend = 1'b0;
  logic          pend_done  = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;

  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (rst) begin
      stall_pend = 1'b0;
      pend_done  = 1'b0;
    end else begin
      if (pend_done) begin
        check("done_after_last", done, 1);
        check("busy_during_done", busy, 1);
        pend_done = 1'b0;
      end else if (done) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done: done=1, expected 0 (t=%0t)", $time);
      end
      if (done) n_done++;
      if (stall_pend) begin
        check("stall_valid", strm.out_valid, 1);
        check("stall_data", strm.data_out, stall_data);
        check("stall_last", strm.out_last, stall_last);
        stall_pend = 1'b0;
      end
      if (strm.out_valid && strm.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: data 0x%0h, expected no beat", strm.data_out);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", strm.data_out, e.data);
          check("beat_last", strm.out_last, e.last);
          if (e.idx == 0) first_cyc = cyc;
          if (e.last) begin
            last_cyc  = cyc;
            pend_done = 1'b1;
          end
        end
      end else if (strm.out_valid) begin
        stall_pend = 1'b1;
        stall_data = strm.data_out;
        stall_last = strm.out_last;
      end
    end
  end

  task automatic wr(input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    if (addr < int'(LEN)) exp_mem[addr] = data;
    tick;
    wr_en = 1'b0;
  endtask

  // pat 0: ready high; pat 1: ready 1,0,0 repeating.
  task automatic run_frame(input int pat, input int wr_at, input int start_at,
                           input int rst_at, input bit wr_with_start);
    int d0;
    d0 = n_done;
    if (wr_with_start) begin
      wr_en      = 1'b1;
      wr_addr    = '0;
      wr_data    = 16'hBEEF;
      exp_mem[0] = 16'hBEEF;
    end
    for (int i = 0; i < int'(LEN); i++) exp_q.push_back('{exp_mem[i], (i == int'(LEN) - 1), i});
    strm.out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    wr_en = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_latency1", strm.out_valid, 0);
    for (int c = 0; c < 2000; c++) begin
      strm.out_ready = (pat == 0) ? 1'b1 : ((c % 3) == 0);
      if (c == wr_at) begin
        wr_en   = 1'b1;
        wr_addr = AW'(5);
        wr_data = 16'hDEAD;
      end
      if (c == start_at) start = 1'b1;
      if (c == rst_at) begin
        rst = 1'b1;
        exp_q.delete();
      end
      tick;
      wr_en = 1'b0;
      start = 1'b0;
      if (c == 0) begin
        check("first_valid", strm.out_valid, 1);
        check("first_data", strm.data_out, exp_mem[0]);
      end
      if (c == wr_at) check("wr_err_streaming", wr_err, 1);
      if (c == rst_at) begin
        rst = 1'b0;
        check("rst_valid", strm.out_valid, 0);
        check("rst_data", strm.data_out, 0);
        check("rst_last", strm.out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_err", wr_err, 0);
        for (int k = 0; k < 4; k++) tick;
        check("no_done_after_abort", n_done, d0);
        return;
      end
      if (n_done != d0) break;
    end
    for (int k = 0; k < 3; k++) tick;
    check("one_done_per_frame", n_done, d0 + 1);
    check("all_beats_seen", exp_q.size(), 0);
    check("idle_after_frame", busy, 0);
  endtask

  initial begin
    strm.out_ready = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    check("reset_valid", strm.out_valid, 0);
    check("reset_data", strm.data_out, 0);
    check("reset_last", strm.out_last, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wr_err", wr_err, 0);
    rst = 1'b0;

    for (int i = 0; i < int'(LEN); i++) wr(i, 16'h0100 + DW'(i));
    check("wr_err_legal", wr_err, 0);

    run_frame(0, -1, -1, -1, 1'b0);
    check("throughput", last_cyc - first_cyc, int'(LEN) - 1);

    run_frame(1, -1, -1, -1, 1'b0);

    wr(int'(LEN), 16'hDEAD);
    check("wr_err_addr", wr_err, 1);
    tick;
    check("wr_err_pulse", wr_err, 0);

    run_frame(0, 20, -1, -1, 1'b0);
    run_frame(0, -1, 52, -1, 1'b0);
    run_frame(0, -1, -1, 72, 1'b0);
    run_frame(1, -1, -1, -1, 1'b0);
    run_frame(0, -1, -1, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
